// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receiver that rebuilds bytes from a serial line.
// Latency: SYNC_STAGES clocks of synchronizer; rx_valid rises 1 clk after the last stop sample.
// Backpressure: one-entry valid/ready holding register; a frame arriving while it is full
// is dropped and flagged as overrun.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rx                 - serial input, idle high
//   br_div/word/stop   - baud divider (0 acts as 1), 7-bit select, 2-stop select
//   en                 - receiver enable; dropping it aborts a frame in flight
//   rx_data/rx_valid   - holding register output, accepted with rx_ready
//   frame_err/overrun  - sticky error flags, cleared by err_clr (set has priority)
//   busy               - a frame is being received
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after the data
// bits and a sticky parity_err output.
module uart_rx_deframer #(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] br_div,
  input  logic       word,
  input  logic       stop,
  input  logic       en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  // Wide enough for OVS * 255 clocks per bit.
  localparam int CW = $clog2(OVS * 256 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          half_lim;
  logic [CW-1:0]          bit_lim;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [7:0]             data_byte;
  logic [7:0]             div;
  logic                   word_l;
  logic                   stop_l;
  logic                   start_det;
  logic                   tick;
  logic                   last_bit;
  logic                   done;
  logic                   load;
  logic                   ovr_set;
  logic                   ferr_set;

  // Input synchronizer; resets to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign div  = (br_div == 8'd0) ? 8'd1 : br_div;

  // 7-bit frames end with the data in shreg[7:1]; right-justify them.
  assign data_byte = word_l ? {1'b0, shreg[7:1]} : shreg;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next-state logic; losing enable beats every other transition.
  always_comb begin
    state_n = state;
    if (state != S_IDLE && !en) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_det) state_n = S_START;
        S_START: if (tick) state_n = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
        S_DATA:  if (tick && last_bit) state_n = S_PAR;
`else
        S_DATA:  if (tick && last_bit) state_n = S_STOP1;
`endif
        S_PAR:   if (tick) state_n = S_STOP1;
        S_STOP1: if (tick) state_n = stop_l ? S_STOP2 : S_IDLE;
        S_STOP2: if (tick) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // FSM outputs. The cycle the start edge is seen already counts as busy, so busy
  // covers the whole frame from the first synchronized low sample.
  always_comb begin
    start_det = (state == S_IDLE) && en && rx_prev && !rx_s;
    busy      = (state != S_IDLE) || start_det;
    tick      = 1'b0;
    if (en) begin
      case (state)
        S_IDLE:  tick = 1'b0;
        S_START: tick = (cnt == half_lim);
        default: tick = (cnt == bit_lim);
      endcase
    end
    last_bit = (bit_cnt == (word_l ? 3'd6 : 3'd7));
    done     = tick && ((state == S_STOP1 && !stop_l) || state == S_STOP2);
    ferr_set = tick && (state == S_STOP1 || state == S_STOP2) && !rx_s;
  end

  assign load    = done && (!rx_valid || rx_ready);
  assign ovr_set = done && rx_valid && !rx_ready;

  // Bit timer, shift register and holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      half_lim  <= '0;
      bit_lim   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      word_l    <= 1'b0;
      stop_l    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Counter starts at 1 on the detect cycle so the start sample lands
      // exactly half a bit after the first low sample.
      if (start_det) begin
        cnt      <= CW'(1);
        half_lim <= CW'(OVS / 2) * CW'(div);
        bit_lim  <= CW'(OVS) * CW'(div) - CW'(1);
        word_l   <= word;
        stop_l   <= stop;
        bit_cnt  <= '0;
      end else if (tick) begin
        cnt <= '0;
      end else if (state != S_IDLE) begin
        cnt <= cnt + CW'(1);
      end

      if (tick && state == S_DATA) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (load) begin
        rx_data  <= data_byte;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set;

  // Even parity: data bits xor parity bit must be zero.
  assign par_set = tick && (state == S_PAR) && ((^data_byte) ^ rx_s);

  always_ff @(posedge clk) begin
    if (rst)          parity_err <= 1'b0;
    else if (par_set) parity_err <= 1'b1;
    else if (err_clr) parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: drives serial frames into uart_rx_deframer and compares the
// delivered bytes, their arrival cycle and the error flags against values computed
// from the frame format (bit period, bit count, stop bits).
module tb_uart_rx_deframer;

  localparam int OVS  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       rx       = 1'b1;
  logic [7:0] br_div   = 8'd8;
  logic       word     = 1'b0;
  logic       stop     = 1'b0;
  logic       en       = 1'b1;
  logic       rx_ready = 1'b1;
  logic       err_clr  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;
  ev_t  evq[$];
  logic vprev = 1'b0;

  uart_rx_deframer #(.OVS(OVS), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .br_div    (br_div),
    .word      (word),
    .stop      (stop),
    .en        (en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every rising edge of rx_valid with its cycle and byte.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && vprev !== 1'b1) evq.push_back('{cyc, rx_data});
    vprev <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle on which rx_valid must first read high for a frame whose line went low at t0-SYNC.
  function automatic int t_valid(input int t0, input int nb, input int ns, input int p);
    return t0 + p / 2 + p * (nb + NPAR + ns) + 1;
  endfunction

  // Advance to the negedge inside cycle c (bounded: cyc always advances).
  task automatic wait_until(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic hold(input int p);
    repeat (p) @(posedge clk);
    #1;
  endtask

  // Caller is just after a posedge; the start bit begins in the current cycle.
  task automatic send_frame(input logic [7:0] d, input int nb, input int ns,
                            input logic [1:0] sv, input int p);
    logic par;
    par = 1'b0;
    rx = 1'b0;
    hold(p);
    for (int i = 0; i < nb; i++) begin
      rx  = d[i];
      par = par ^ d[i];
      hold(p);
    end
    if (NPAR != 0) begin
      rx = par;
      hold(p);
    end
    rx = sv[0];
    hold(p);
    if (ns == 2) begin
      rx = sv[1];
      hold(p);
    end
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int tv, input logic [7:0] d);
    ev_t ev;
    check({tag, "_cnt"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      check({tag, "_cyc"}, ev.c, tv);
      check({tag, "_dat"}, ev.d, d);
    end
    evq.delete();
  endtask

  task automatic pulse_clr;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int         t0;
    int         ta;
    int         p;
    int         nb;
    int         ns;
    int         dv;
    logic [7:0] d;
    logic [7:0] exp_d;
    logic [1:0] sv;
    logic       w7;
    logic       s2;
    logic       exp_ferr;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // 0x8E, div 8, 8N1, ready=1: one-cycle valid pulse at T0+1217
    p  = OVS * 8;
    t0 = cyc + SYNC;
    fork
      send_frame(8'h8E, 8, 1, 2'b11, p);
      begin
        wait_until(t0);
        check("8e_busy_t0", busy, 1);
        wait_until(t_valid(t0, 8, 1, p) - 1);
        check("8e_busy_last", busy, 1);
        @(negedge clk);
        check("8e_vhi", rx_valid, 1);
        check("8e_busy_done", busy, 0);
        @(negedge clk);
        check("8e_vlo", rx_valid, 0);
      end
    join
    expect_frame("8e", t_valid(t0, 8, 1, p), 8'h8E);
    check("8e_ferr", frame_err, 0);
    check("8e_ovr", overrun, 0);

    // 0xFF then 0xF0 back-to-back with ready=0: overrun, first byte kept
    rx_ready = 1'b0;
    ta = cyc + SYNC;
    send_frame(8'hFF, 8, 1, 2'b11, p);
    send_frame(8'hF0, 8, 1, 2'b11, p);
    expect_frame("ovr1", t_valid(ta, 8, 1, p), 8'hFF);
    check("ovr_flag", overrun, 1);
    check("ovr_data", rx_data, 8'hFF);
    check("ovr_valid", rx_valid, 1);
    pulse_clr();
    @(negedge clk);
    check("ovr_clr", overrun, 0);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_drain", rx_valid, 0);
    @(posedge clk);
    #1;

    // 7-bit, 2 stop bits, 0x55 with the second stop bit low
    word = 1'b1;
    stop = 1'b1;
    t0   = cyc + SYNC;
    send_frame(8'h55, 7, 2, 2'b01, p);
    expect_frame("w7", t_valid(t0, 7, 2, p), 8'h55);
    check("w7_ferr", frame_err, 1);
    check("w7_valid", rx_valid, 1);
    word = 1'b0;
    stop = 1'b0;

    // rst pulsed mid-DATA: everything back to reset values on the next cycle
    t0 = cyc + SYNC;
    rx = 1'b0;
    wait_until(t0 + 300);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", rx_valid, 0);
    check("mrst_data", rx_data, 0);
    check("mrst_ferr", frame_err, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_busy", busy, 0);
    repeat (50) @(posedge clk);
    #1;
    rx_ready = 1'b1;
    t0 = cyc + SYNC;
    send_frame(8'hA5, 8, 1, 2'b11, p);
    expect_frame("a5", t_valid(t0, 8, 1, p), 8'hA5);

    // 20-clock glitch: false start, idle again at T0+65, nothing delivered
    t0 = cyc + SYNC;
    rx = 1'b0;
    hold(20);
    rx = 1'b1;
    wait_until(t0 + 64);
    check("gl_busy64", busy, 1);
    @(negedge clk);
    check("gl_busy65", busy, 0);
    repeat (300) @(posedge clk);
    #1;
    check("gl_none", evq.size(), 0);
    check("gl_ferr", frame_err, 0);

    // en dropped at T0+500: abort next cycle, then 0x3C after re-enable
    t0 = cyc + SYNC;
    fork
      send_frame(8'hC3, 8, 1, 2'b11, p);
      begin
        wait_until(t0 + 500);
        check("en_busy500", busy, 1);
        en = 1'b0;
        @(negedge clk);
        check("en_busy501", busy, 0);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("en_none", evq.size(), 0);
    check("en_ferr", frame_err, 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc + SYNC;
    send_frame(8'h3C, 8, 1, 2'b11, p);
    expect_frame("3c", t_valid(t0, 8, 1, p), 8'h3C);

    // Randomized frames: format, divider, data and stop-bit corruption
    for (int n = 0; n < 14; n++) begin
      d        = 8'($urandom);
      w7       = 1'($urandom);
      s2       = 1'($urandom);
      dv       = $urandom_range(0, 3);
      sv       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      nb       = w7 ? 7 : 8;
      ns       = s2 ? 2 : 1;
      p        = OVS * ((dv == 0) ? 1 : dv);
      exp_d    = w7 ? {1'b0, d[6:0]} : d;
      exp_ferr = !sv[0] || (s2 && !sv[1]);
      br_div   = 8'(dv);
      word     = w7;
      stop     = s2;
      t0       = cyc + SYNC;
      send_frame(d, nb, ns, sv, p);
      expect_frame($sformatf("rnd%0d", n), t_valid(t0, nb, ns, p), exp_d);
      check($sformatf("rnd%0d_ferr", n), frame_err, exp_ferr);
      check($sformatf("rnd%0d_ovr", n), overrun, 0);
`ifdef UART_RX_PARITY_EN
      check($sformatf("rnd%0d_perr", n), parity_err, 0);
`endif
      pulse_clr();
      @(negedge clk);
      check($sformatf("rnd%0d_clr", n), frame_err, 0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
